// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes,
// FSM state encoding and the datapath mux / ALU-control encodings.
package mc_ctrl_fsm_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Controller states
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } mc_state_t;

    // Register-file write-back source
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    // ALU operand A source
    localparam logic [1:0] A_OLD_PC = 2'd0;
    localparam logic [1:0] A_RS1    = 2'd1;
    localparam logic [1:0] A_PC     = 2'd2;

    // ALU operand B source
    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_FOUR = 2'd1;
    localparam logic [1:0] B_IMM  = 2'd2;

    // ALU control request
    localparam logic [1:0] F_ADD    = 2'd0;
    localparam logic [1:0] F_DECODE = 2'd1;
    localparam logic [1:0] F_BRANCH = 2'd2;
    localparam logic [1:0] F_PASS_B = 2'd3;

endpackage

// File: rtl/mc_perf_counters.sv
// Cycle and retired-instruction counters; both wrap modulo 2^CNT_W.
module mc_perf_counters
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    // Count active cycles and retirements; cleared while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (count_en) cycle_cnt   <= cycle_cnt + CNT_W'(1);
            if (retire)   instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I controller: sequences IF/ID/EX/MEM/WB over one shared
// memory port, drives datapath selects/enables, detects halt conditions.
//
// Memory handshake: mem_req is held high for the whole request; the request
// completes on the first cycle in which mem_ready is sampled high while
// mem_req is high. mem_ready while mem_req is low is ignored. mem_we and
// i_or_d are only meaningful while mem_req is high.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             bcond,
    input  logic             ecall_halt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_func,
    output logic             is_halted,
    output logic             illegal_inst,
    output logic             bus_error,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output mc_state_t        dbg_state
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    mc_state_t        state_q, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_expire;
    logic             waiting;
    logic             retire;
    logic             set_illegal;
    logic             set_bus_err;
    logic             illegal_q;
    logic             bus_err_q;

    assign dbg_state    = state_q;
    assign illegal_inst = illegal_q;
    assign bus_error    = bus_err_q;
    // This waiting cycle is the MEM_TIMEOUT-th one of the current request.
    assign tmo_expire   = (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IF;
        else        state_q <= state_nxt;
    end

    // Wait counter: counts stalled request cycles, restarts whenever the
    // port is not stalled (so it is zero on every entry to IF or MEM).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       tmo_cnt <= '0;
        else if (waiting) tmo_cnt <= tmo_cnt + TMO_W'(1);
        else              tmo_cnt <= '0;
    end

    // Sticky halt-cause flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
        end
    end

    // Next-state and control-output decode.
    always_comb begin
        state_nxt   = state_q;
        waiting     = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = WB_ALUOUT;
        alu_a_sel   = A_OLD_PC;
        alu_b_sel   = B_RS2;
        alu_func    = F_ADD;
        is_halted   = 1'b0;

        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                i_or_d  = 1'b0;
                if (mem_ready) begin
                    // Latch IR/old_pc and advance PC <= PC + 4.
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = 1'b0;
                    alu_a_sel = A_PC;
                    alu_b_sel = B_FOUR;
                    alu_func  = F_ADD;
                    state_nxt = S_ID;
                end else begin
                    waiting = 1'b1;
                    if (tmo_expire) begin
                        set_bus_err = 1'b1;
                        state_nxt   = S_HALT;
                    end
                end
            end

            S_ID: begin
                // Speculatively compute old_pc + imm into ALUOut.
                alu_a_sel = A_OLD_PC;
                alu_b_sel = B_IMM;
                alu_func  = F_ADD;
                case (opcode)
                    OPC_AUIPC: state_nxt = S_WB;
                    OPC_SYSTEM: begin
                        retire    = 1'b1;
                        state_nxt = ecall_halt ? S_HALT : S_IF;
                    end
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_LOAD, OPC_STORE,
                    OPC_BRANCH, OPC_JAL, OPC_JALR: state_nxt = S_EX;
                    default: begin
                        set_illegal = 1'b1;
                        state_nxt   = S_HALT;
                    end
                endcase
            end

            S_EX: begin
                case (opcode)
                    OPC_OP: begin
                        alu_a_sel = A_RS1;
                        alu_b_sel = B_RS2;
                        alu_func  = F_DECODE;
                        state_nxt = S_WB;
                    end
                    OPC_OP_IMM: begin
                        alu_a_sel = A_RS1;
                        alu_b_sel = B_IMM;
                        alu_func  = F_DECODE;
                        state_nxt = S_WB;
                    end
                    OPC_LUI: begin
                        alu_b_sel = B_IMM;
                        alu_func  = F_PASS_B;
                        state_nxt = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_a_sel = A_RS1;
                        alu_b_sel = B_IMM;
                        alu_func  = F_ADD;
                        state_nxt = S_MEM;
                    end
                    OPC_BRANCH: begin
                        // Target was precomputed into ALUOut during ID.
                        alu_a_sel = A_RS1;
                        alu_b_sel = B_RS2;
                        alu_func  = F_BRANCH;
                        pc_write  = bcond;
                        pc_src    = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                    OPC_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                    OPC_JALR: begin
                        // Datapath clears bit 0 of the ALU result.
                        alu_a_sel = A_RS1;
                        alu_b_sel = B_IMM;
                        alu_func  = F_ADD;
                        pc_write  = 1'b1;
                        pc_src    = 1'b0;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end
                    default: begin
                        // IR changed under us; treat as an illegal opcode.
                        set_illegal = 1'b1;
                        state_nxt   = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (opcode == OPC_STORE);
                if (mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        retire    = 1'b1;
                        state_nxt = S_IF;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else begin
                    waiting = 1'b1;
                    if (tmo_expire) begin
                        set_bus_err = 1'b1;
                        state_nxt   = S_HALT;
                    end
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OPC_LOAD) ? WB_MDR : WB_ALUOUT;
                retire    = 1'b1;
                state_nxt = S_IF;
            end

            S_HALT: begin
                is_halted = 1'b1;
            end

            default: state_nxt = S_IF;
        endcase

        // Hold every control output low while reset is asserted.
        if (!reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            i_or_d    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 2'd0;
            alu_a_sel = 2'd0;
            alu_b_sel = 2'd0;
            alu_func  = 2'd0;
            is_halted = 1'b0;
        end
    end

    mc_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .reset       (reset),
        .count_en    (state_q != S_HALT),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed instruction sequences; per-cycle expected
// control words queued by the driver, compared by a negedge monitor.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    localparam int CNT_W = 32;
    localparam int W     = 18;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [6:0]       opcode;
    logic             bcond, ecall_halt, mem_ready;
    logic             mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write;
    logic [1:0]       wb_sel, alu_a_sel, alu_b_sel, alu_func;
    logic             is_halted, illegal_inst, bus_error;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
    mc_state_t        dbg_state;

    mc_ctrl_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .ecall_halt(ecall_halt), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_func(alu_func), .is_halted(is_halted),
        .illegal_inst(illegal_inst), .bus_error(bus_error),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        lbl_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    function automatic logic [W-1:0] cw(
        input logic req, we, iod, irw, pcw, pcs, rw,
        input logic [1:0] wb, a, b, f,
        input logic h, ill, be);
        return {req, we, iod, irw, pcw, pcs, rw, wb, a, b, f, h, ill, be};
    endfunction

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every cycle with an expectation queued, compare the control word.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            automatic logic [W-1:0] exp = exp_q.pop_front();
            automatic string        lbl = lbl_q.pop_front();
            automatic logic [W-1:0] act = {mem_req, mem_we, i_or_d, ir_write, pc_write,
                                           pc_src, reg_write, wb_sel, alu_a_sel, alu_b_sel,
                                           alu_func, is_halted, illegal_inst, bus_error};
            n_checks++;
            if (act === exp) n_pass++;
            else $display("FAIL ctrl %s: got %b expected %b", lbl, act, exp);
        end
    end

    // ---------------- driver ----------------
    logic [W-1:0] w_zero, w_if_wait, w_if_done, w_id, w_ex_alui, w_ex_ls, w_ex_lui;
    logic [W-1:0] w_ex_br_t, w_ex_br_n, w_ex_jal, w_mem_ld, w_mem_st, w_wb_alu, w_wb_ld;
    logic [W-1:0] w_halt, w_halt_ill, w_halt_bus;

    // Apply inputs for one cycle (called at posedge+1), queue the expected word.
    task automatic step(input logic [6:0] op, input logic rdy, input logic bc,
                        input logic eh, input logic [W-1:0] exp, input string lbl);
        opcode     = op;
        mem_ready  = rdy;
        bcond      = bc;
        ecall_halt = eh;
        exp_q.push_back(exp);
        lbl_q.push_back(lbl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(7'd0, 1'b0, 1'b0, 1'b0, w_zero, "in_reset");
        check("cycle_cnt_in_reset", cycle_cnt, 0);
        check("instret_cnt_in_reset", instret_cnt, 0);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w_zero     = '0;
        w_if_wait  = cw(1,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0);
        w_if_done  = cw(1,0,0,1,1,0,0, 2'd0,2'd2,2'd1,2'd0, 0,0,0);
        w_id       = cw(0,0,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd0, 0,0,0);
        w_ex_alui  = cw(0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd1, 0,0,0);
        w_ex_ls    = cw(0,0,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0, 0,0,0);
        w_ex_lui   = cw(0,0,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd3, 0,0,0);
        w_ex_br_t  = cw(0,0,0,0,1,1,0, 2'd0,2'd1,2'd0,2'd2, 0,0,0);
        w_ex_br_n  = cw(0,0,0,0,0,1,0, 2'd0,2'd1,2'd0,2'd2, 0,0,0);
        w_ex_jal   = cw(0,0,0,0,1,1,1, 2'd2,2'd0,2'd0,2'd0, 0,0,0);
        w_mem_ld   = cw(1,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0);
        w_mem_st   = cw(1,1,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0,0);
        w_wb_alu   = cw(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0,0,0);
        w_wb_ld    = cw(0,0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0, 0,0,0);
        w_halt     = cw(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,0,0);
        w_halt_ill = cw(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,1,0);
        w_halt_bus = cw(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1,0,1);

        reset = 1'b0; opcode = '0; bcond = 0; ecall_halt = 0; mem_ready = 0;
        @(posedge clk);
        #1;
        step(7'd0, 1'b0, 1'b0, 1'b0, w_zero, "reset_a");
        do_reset();

        // addi: IF(ready at once), ID, EX, WB = 4 cycles
        step(OPC_OP_IMM, 1, 0, 0, w_if_done, "addi_if");
        step(OPC_OP_IMM, 0, 0, 0, w_id,      "addi_id");
        step(OPC_OP_IMM, 0, 0, 0, w_ex_alui, "addi_ex");
        step(OPC_OP_IMM, 0, 0, 0, w_wb_alu,  "addi_wb");
        check("addi_cycle_cnt", cycle_cnt, 4);
        check("addi_instret", instret_cnt, 1);

        // lw with 3 stall cycles in IF and in MEM = 11 cycles
        for (int i = 0; i < 3; i++) step(OPC_LOAD, 0, 0, 0, w_if_wait, "lw_if_wait");
        step(OPC_LOAD, 1, 0, 0, w_if_done, "lw_if");
        step(OPC_LOAD, 0, 0, 0, w_id,      "lw_id");
        step(OPC_LOAD, 0, 0, 0, w_ex_ls,   "lw_ex");
        for (int i = 0; i < 3; i++) step(OPC_LOAD, 0, 0, 0, w_mem_ld, "lw_mem_wait");
        step(OPC_LOAD, 1, 0, 0, w_mem_ld,  "lw_mem");
        step(OPC_LOAD, 0, 0, 0, w_wb_ld,   "lw_wb");
        check("lw_cycle_cnt", cycle_cnt, 15);
        check("lw_instret", instret_cnt, 2);

        // beq taken, then not taken: 3 cycles each
        step(OPC_BRANCH, 1, 0, 0, w_if_done, "beq_t_if");
        step(OPC_BRANCH, 0, 0, 0, w_id,      "beq_t_id");
        step(OPC_BRANCH, 0, 1, 0, w_ex_br_t, "beq_t_ex");
        check("beq_t_cycle_cnt", cycle_cnt, 18);
        step(OPC_BRANCH, 1, 0, 0, w_if_done, "beq_n_if");
        step(OPC_BRANCH, 0, 0, 0, w_id,      "beq_n_id");
        step(OPC_BRANCH, 0, 0, 0, w_ex_br_n, "beq_n_ex");
        check("beq_n_cycle_cnt", cycle_cnt, 21);
        check("beq_instret", instret_cnt, 4);

        // jal (3), lui (4), auipc (3), sw (4)
        step(OPC_JAL, 1, 0, 0, w_if_done, "jal_if");
        step(OPC_JAL, 0, 0, 0, w_id,      "jal_id");
        step(OPC_JAL, 0, 0, 0, w_ex_jal,  "jal_ex");
        step(OPC_LUI, 1, 0, 0, w_if_done, "lui_if");
        step(OPC_LUI, 0, 0, 0, w_id,      "lui_id");
        step(OPC_LUI, 0, 0, 0, w_ex_lui,  "lui_ex");
        step(OPC_LUI, 0, 0, 0, w_wb_alu,  "lui_wb");
        step(OPC_AUIPC, 1, 0, 0, w_if_done, "auipc_if");
        step(OPC_AUIPC, 0, 0, 0, w_id,      "auipc_id");
        step(OPC_AUIPC, 0, 0, 0, w_wb_alu,  "auipc_wb");
        step(OPC_STORE, 1, 0, 0, w_if_done, "sw_if");
        step(OPC_STORE, 0, 0, 0, w_id,      "sw_id");
        step(OPC_STORE, 0, 0, 0, w_ex_ls,   "sw_ex");
        step(OPC_STORE, 1, 0, 0, w_mem_st,  "sw_mem");
        check("mix_cycle_cnt", cycle_cnt, 35);
        check("mix_instret", instret_cnt, 8);

        // ecall without halt retires and returns to IF
        step(OPC_SYSTEM, 1, 0, 0, w_if_done, "ecall_if");
        step(OPC_SYSTEM, 0, 0, 0, w_id,      "ecall_id");
        check("ecall_cycle_cnt", cycle_cnt, 37);
        check("ecall_instret", instret_cnt, 9);

        // ecall with halt: retires, then absorbing HALT with frozen cycle_cnt
        step(OPC_SYSTEM, 1, 0, 1, w_if_done, "ecall_h_if");
        step(OPC_SYSTEM, 0, 0, 1, w_id,      "ecall_h_id");
        for (int i = 0; i < 20; i++) step(7'(i * 5), i[0], i[1], 1'b0, w_halt, "halted");
        check("halt_cycle_cnt", cycle_cnt, 39);
        check("halt_instret", instret_cnt, 10);

        // illegal opcode 0000000
        do_reset();
        step(7'b0000000, 1, 0, 0, w_if_done, "ill_if");
        step(7'b0000000, 0, 0, 0, w_id,      "ill_id");
        for (int i = 0; i < 3; i++) step(7'b0000000, 1, 0, 0, w_halt_ill, "ill_halt");
        check("ill_cycle_cnt", cycle_cnt, 2);
        check("ill_instret", instret_cnt, 0);

        // IF timeout with MEM_TIMEOUT=4
        do_reset();
        for (int i = 0; i < 4; i++) step(OPC_OP, 0, 0, 0, w_if_wait, "tmo_if_wait");
        for (int i = 0; i < 2; i++) step(OPC_OP, 0, 0, 0, w_halt_bus, "tmo_halt");
        check("tmo_cycle_cnt", cycle_cnt, 4);
        check("tmo_instret", instret_cnt, 0);

        // reset during a stalled sw MEM access aborts it
        do_reset();
        step(OPC_STORE, 1, 0, 0, w_if_done, "swr_if");
        step(OPC_STORE, 0, 0, 0, w_id,      "swr_id");
        step(OPC_STORE, 0, 0, 0, w_ex_ls,   "swr_ex");
        step(OPC_STORE, 0, 0, 0, w_mem_st,  "swr_mem");
        check("swr_pre_cycle_cnt", cycle_cnt, 4);
        reset = 1'b0;
        step(OPC_STORE, 1, 0, 0, w_zero, "swr_in_reset");
        check("swr_reset_cycle_cnt", cycle_cnt, 0);
        check("swr_reset_instret", instret_cnt, 0);
        reset = 1'b1;
        step(OPC_STORE, 0, 0, 0, w_if_wait, "swr_after_if");
        step(OPC_OP, 1, 0, 0, w_if_done, "add_if");
        step(OPC_OP, 0, 0, 0, w_id,      "add_id");
        step(OPC_OP, 0, 0, 0, cw(0,0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd1, 0,0,0), "add_ex");
        step(OPC_OP, 0, 0, 0, w_wb_alu,  "add_wb");
        check("recover_cycle_cnt", cycle_cnt, 5);
        check("recover_instret", instret_cnt, 1);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
